// File: rtl/clfsr_pkg.sv
// Shared constants, FSM encoding and mode-bit positions for the chaotic-LFSR stream cipher.
package clfsr_pkg;

    localparam int unsigned DEF_CHANNELS     = 3;
    localparam int unsigned DEF_PIXEL_W      = 8;
    localparam int unsigned DEF_LFSR_W       = 32;
    localparam logic [31:0] DEF_TAPS         = 32'h8020_0003;
    localparam int unsigned DEF_FRAME_PIXELS = 65536;

    localparam int unsigned MODE_DEC  = 0;
    localparam int unsigned MODE_DIFF = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/clfsr_keygen.sv
// Galois LFSR keystream source: seed load with zero-seed fix, one step per enabled cycle.
module clfsr_keygen
    import clfsr_pkg::*;
#(
    parameter int unsigned       LFSR_W = DEF_LFSR_W,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEF_TAPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              step,
    output logic [LFSR_W-1:0] state
);

    // A zero seed would lock the register, so it is replaced by 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LFSR_W'(1);
        end else if (load) begin
            state <= (seed == '0) ? LFSR_W'(1) : seed;
        end else if (step) begin
            state <= state[0] ? ((state >> 1) ^ TAPS) : (state >> 1);
        end
    end

endmodule

// File: rtl/clfsr_stream_cipher.sv
// Streaming pixel cipher: XOR or add-diffusion of each channel with a Galois-LFSR keystream,
// one pixel per handshake, single registered output stage, frame-end flag and done pulse.
module clfsr_stream_cipher
    import clfsr_pkg::*;
#(
    parameter int unsigned       CHANNELS     = DEF_CHANNELS,
    parameter int unsigned       PIXEL_W      = DEF_PIXEL_W,
    parameter int unsigned       LFSR_W       = DEF_LFSR_W,
    parameter logic [LFSR_W-1:0] TAPS         = LFSR_W'(DEF_TAPS),
    parameter int unsigned       FRAME_PIXELS = DEF_FRAME_PIXELS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          seed_load,
    input  logic [LFSR_W-1:0]             seed,
    input  logic [1:0]                    mode,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [CHANNELS*PIXEL_W-1:0]   s_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [CHANNELS*PIXEL_W-1:0]   m_data,
    output logic                          m_last,
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned DATA_W = CHANNELS * PIXEL_W;
    localparam int unsigned CNT_W  = $clog2(FRAME_PIXELS + 1);

    if (DATA_W > LFSR_W) begin : g_width_check
        $error("clfsr_stream_cipher: CHANNELS*PIXEL_W must not exceed LFSR_W");
    end

    state_e              state, state_nxt;
    logic [LFSR_W-1:0]   lfsr;
    logic                lfsr_load, lfsr_step;
    logic [1:0]          mode_r, mode_nxt;
    logic [CNT_W-1:0]    count, count_nxt;
    logic [DATA_W-1:0]   out_px, m_data_nxt;
    logic                m_valid_nxt, m_last_nxt, done_nxt, busy_nxt;
    logic                xfer, last_px;
    logic                unused_lfsr;

    clfsr_keygen #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS)
    ) u_keygen (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load),
        .seed  (seed),
        .step  (lfsr_step),
        .state (lfsr)
    );

    // State bits above the key slice only feed the LFSR recurrence.
    assign unused_lfsr = ^lfsr;

    assign s_ready = (state == RUN) && (!m_valid || m_ready);
    assign xfer    = s_valid && s_ready;
    assign last_px = (count == CNT_W'(FRAME_PIXELS - 1));

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [PIXEL_W-1:0] key, din, sum, dif, prev_c;

        assign key = lfsr[c*PIXEL_W +: PIXEL_W];
        assign din = s_data[c*PIXEL_W +: PIXEL_W];
        assign sum = din + key + prev_c;
        assign dif = din - key - prev_c;
        assign out_px[c*PIXEL_W +: PIXEL_W] =
            !mode_r[MODE_DIFF] ? (din ^ key) : (mode_r[MODE_DEC] ? dif : sum);

        // Chaining value is always the ciphertext byte, which decrypt sees on its input.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                prev_c <= '0;
            end else if (lfsr_load) begin
                prev_c <= '0;
            end else if (xfer) begin
                prev_c <= mode_r[MODE_DEC] ? din : out_px[c*PIXEL_W +: PIXEL_W];
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        mode_nxt    = mode_r;
        count_nxt   = count;
        m_data_nxt  = m_data;
        m_valid_nxt = m_valid;
        m_last_nxt  = m_last;
        done_nxt    = 1'b0;
        lfsr_load   = 1'b0;
        lfsr_step   = 1'b0;
        unique case (state)
            IDLE: begin
                if (seed_load) begin
                    lfsr_load = 1'b1;
                    mode_nxt  = mode;
                    count_nxt = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (xfer) begin
                    m_data_nxt  = out_px;
                    m_valid_nxt = 1'b1;
                    m_last_nxt  = last_px;
                    count_nxt   = count + CNT_W'(1);
                    lfsr_step   = 1'b1;
                    if (last_px) begin
                        state_nxt = FLUSH;
                    end
                end else if (m_ready) begin
                    m_valid_nxt = 1'b0;
                    m_last_nxt  = 1'b0;
                end
            end
            FLUSH: begin
                if (m_valid && m_ready) begin
                    m_valid_nxt = 1'b0;
                    m_last_nxt  = 1'b0;
                    done_nxt    = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            mode_r  <= '0;
            count   <= '0;
            m_data  <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            mode_r  <= mode_nxt;
            count   <= count_nxt;
            m_data  <= m_data_nxt;
            m_valid <= m_valid_nxt;
            m_last  <= m_last_nxt;
            done    <= done_nxt;
            busy    <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_clfsr_stream_cipher.sv
// Directed bench for clfsr_stream_cipher with a 16-pixel frame.
module tb_clfsr_stream_cipher;

    localparam int unsigned CH = 3;
    localparam int unsigned PW = 8;
    localparam int unsigned LW = 32;
    localparam int unsigned FP = 16;
    localparam int unsigned DW = CH * PW;
    localparam logic [31:0] TAPS = 32'h8020_0003;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          seed_load = 1'b0;
    logic [LW-1:0] seed = '0;
    logic [1:0]    mode = '0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          m_ready = 1'b0;
    logic          s_ready, m_valid, m_last, busy, done;
    logic [DW-1:0] m_data;

    int n_checks = 0;
    int n_errs   = 0;

    logic [DW-1:0] outq[$];
    logic          lastq[$];
    int            cyc = 0;
    int            last_cyc = -1;
    int            done_cyc = -1;
    int            done_cnt = 0;

    logic [DW-1:0] mdl_in[16];
    logic [DW-1:0] mdl_out[16];
    logic [DW-1:0] plain[16];
    logic [DW-1:0] cipher[16];

    always #5 clk = ~clk;

    clfsr_stream_cipher #(
        .CHANNELS     (CH),
        .PIXEL_W      (PW),
        .LFSR_W       (LW),
        .TAPS         (TAPS),
        .FRAME_PIXELS (FP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_load),
        .seed      (seed),
        .mode      (mode),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done)
    );

    // Output-side monitor: every accepted beat and every done cycle.
    always @(posedge clk) begin
        if (rst && m_valid && m_ready) begin
            outq.push_back(m_data);
            lastq.push_back(m_last);
            if (m_last) last_cyc = cyc;
        end
        if (rst && done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        s_valid = 1'b0;
        seed_load = 1'b0;
        #20;
        @(posedge clk);
        #1;
        rst = 1'b1;
        outq.delete();
        lastq.delete();
        done_cnt = 0;
    endtask

    task automatic start_frame(input logic [31:0] sd, input logic [1:0] md);
        seed = sd;
        mode = md;
        seed_load = 1'b1;
        @(posedge clk);
        #1;
        seed_load = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] d);
        int   t;
        logic ok;
        t = 0;
        ok = 1'b0;
        s_valid = 1'b1;
        s_data = d;
        do begin
            @(posedge clk);
            ok = s_ready;
            t++;
        end while (!ok && t < 100);
        #1;
        s_valid = 1'b0;
        if (!ok) chk("push_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_done(input int target);
        int t;
        t = 0;
        while (done_cnt < target && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (done_cnt < target) chk("done_timeout", 32'(done_cnt), 32'(target));
    endtask

    // Reference: per-channel cipher against an independently stepped Galois LFSR.
    task automatic model_run(input logic [31:0] sd, input logic [1:0] md, input int n);
        logic [31:0] st;
        logic [PW-1:0] prv[CH];
        logic [PW-1:0] k, x, o;
        st = (sd == 32'd0) ? 32'd1 : sd;
        for (int c = 0; c < CH; c++) prv[c] = '0;
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < CH; c++) begin
                k = st[c*PW +: PW];
                x = mdl_in[i][c*PW +: PW];
                if (!md[1]) begin
                    o = x ^ k;
                end else if (!md[0]) begin
                    o = x + k + prv[c];
                    prv[c] = o;
                end else begin
                    o = x - k - prv[c];
                    prv[c] = x;
                end
                mdl_out[i][c*PW +: PW] = o;
            end
            st = st[0] ? ((st >> 1) ^ TAPS) : (st >> 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] held;

        // Reset state, during and after reset.
        m_ready = 1'b1;
        #12;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        #8;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_s_ready", 32'(s_ready), 32'd0);
        chk("idle_m_valid", 32'(m_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);

        // XOR basic: keystream words 0x000001 then 0x200003.
        start_frame(32'd1, 2'b00);
        chk("xor_busy", 32'(busy), 32'd1);
        push(24'h000000);
        chk("xor_lat_valid", 32'(m_valid), 32'd1);
        chk("xor_px1", 32'(m_data), 32'h000001);
        push(24'h000000);
        chk("xor_px2", 32'(m_data), 32'h200003);

        // Zero seed behaves as seed 1.
        do_reset();
        start_frame(32'd0, 2'b00);
        push(24'h000000);
        chk("zseed_px1", 32'(m_data), 32'h000001);
        push(24'h000000);
        chk("zseed_px2", 32'(m_data), 32'h200003);

        // Backpressure: 5 stalled cycles with a pixel waiting.
        do_reset();
        mdl_in[0] = 24'h102030; mdl_in[1] = 24'hA5A5A5; mdl_in[2] = 24'hFFFFFF;
        mdl_in[3] = 24'h000000; mdl_in[4] = 24'h0F0F0F; mdl_in[5] = 24'h123456;
        model_run(32'h1234_5678, 2'b00, 6);
        start_frame(32'h1234_5678, 2'b00);
        push(mdl_in[0]);
        m_ready = 1'b0;
        held = m_data;
        fork
            push(mdl_in[1]);
            begin
                repeat (5) begin
                    @(posedge clk);
                    #2;
                    chk("bp_s_ready", 32'(s_ready), 32'd0);
                    chk("bp_m_valid", 32'(m_valid), 32'd1);
                    chk("bp_hold", 32'(m_data), 32'(held));
                end
                m_ready = 1'b1;
            end
        join
        for (int i = 2; i < 6; i++) push(mdl_in[i]);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_count", 32'(outq.size()), 32'd6);
        for (int i = 0; i < 6 && i < outq.size(); i++) chk("bp_px", 32'(outq[i]), 32'(mdl_out[i]));

        // Diffusion encrypt over a full frame, with an ignored mid-frame seed_load/mode change.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            plain[i] = DW'($urandom);
            mdl_in[i] = plain[i];
        end
        model_run(32'h0000_ACE1, 2'b10, 16);
        for (int i = 0; i < 16; i++) cipher[i] = mdl_out[i];
        start_frame(32'h0000_ACE1, 2'b10);
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                seed_load = 1'b1;
                seed = 32'hDEAD_BEEF;
                mode = 2'b01;
            end
            push(plain[i]);
            seed_load = 1'b0;
        end
        wait_done(1);
        chk("enc_busy_after", 32'(busy), 32'd0);
        chk("enc_s_ready_after", 32'(s_ready), 32'd0);
        chk("enc_m_valid_after", 32'(m_valid), 32'd0);
        chk("enc_done_lat", 32'(done_cyc), 32'(last_cyc + 1));
        chk("enc_count", 32'(outq.size()), 32'd16);
        for (int i = 0; i < 16 && i < outq.size(); i++) begin
            chk("enc_px", 32'(outq[i]), 32'(cipher[i]));
            chk("enc_last", 32'(lastq[i]), (i == 15) ? 32'd1 : 32'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("enc_done_pulses", 32'(done_cnt), 32'd1);

        // Decrypt the ciphertext and recover the original pixels.
        outq.delete();
        lastq.delete();
        done_cnt = 0;
        start_frame(32'h0000_ACE1, 2'b11);
        for (int i = 0; i < 16; i++) push(cipher[i]);
        wait_done(1);
        chk("dec_count", 32'(outq.size()), 32'd16);
        for (int i = 0; i < 16 && i < outq.size(); i++) chk("dec_px", 32'(outq[i]), 32'(plain[i]));

        // Mid-frame reset aborts without done; a new seed restarts the keystream.
        do_reset();
        start_frame(32'h0000_55AA, 2'b00);
        push(24'h111111);
        push(24'h222222);
        rst = 1'b0;
        #1;
        chk("abort_m_valid", 32'(m_valid), 32'd0);
        chk("abort_m_data", 32'(m_data), 32'd0);
        chk("abort_m_last", 32'(m_last), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_s_ready", 32'(s_ready), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        #20;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        chk("abort_idle_busy", 32'(busy), 32'd0);
        start_frame(32'h0000_55AA, 2'b00);
        push(24'h000000);
        chk("restart_px1", 32'(m_data), 32'h0055AA);
        push(24'h000000);
        chk("restart_px2", 32'(m_data), 32'h002AD5);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
